// File: rtl/delay_ctrl_if.sv
// delay_ctrl_if: sample stream, delay-configuration handshake and status of delay_ctrl.
interface delay_ctrl_if #(
  parameter int D_WIDTH = 16,
  parameter int ADDR_W = 10
);
  logic vld;
  logic [D_WIDTH-1:0] din;
  logic cfg_valid;
  logic [ADDR_W-1:0] cfg_delay;
  logic cfg_ready;
  logic [D_WIDTH-1:0] dout;
  logic dout_vld;
  logic [ADDR_W-1:0] cur_delay;
  logic [1:0] state;
  modport master (
    output vld, din, cfg_valid, cfg_delay,
    input cfg_ready, dout, dout_vld, cur_delay, state
  );
  modport slave (
    input vld, din, cfg_valid, cfg_delay,
    output cfg_ready, dout, dout_vld, cur_delay, state
  );
endinterface

// File: rtl/delay_ctrl.sv
// delay_ctrl: vld-advanced circular-buffer delay line with runtime delay changes.
// Define DELAY_CTRL_FLUSH_EN to re-prime after every delay change instead of switching on the fly.
module delay_ctrl #(
  parameter int D_WIDTH = 16,
  parameter int ADDR_W = 10,
  parameter int DEFAULT_DELAY = 17
) (
  input logic clk,
  input logic reset_n,
  delay_ctrl_if.slave bus
);
  typedef enum logic [1:0] {FILL = 2'd0, RUN = 2'd1, RECONF = 2'd2} state_e;
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, fill_q, fill_d, cur_q, cur_d, req_q, req_d, rd_addr;
  logic [D_WIDTH-1:0] mem [2**ADDR_W];
  logic [D_WIDTH-1:0] dout_q;
  logic dout_vld_q, ready_q, ready_d, emit, accept;
  assign rd_addr = wr_ptr_q - (cur_q - ONE);
  assign accept = bus.cfg_valid && ready_q;
  // fill_q sits at cur_q-1 once primed, so every vld emits in RUN
  always_comb begin
    emit = bus.vld && (fill_q == cur_q - ONE);
    state_d = state_q;
    fill_d = (bus.vld && !emit) ? fill_q + ONE : fill_q;
    cur_d = cur_q;
    req_d = req_q;
    if (emit && state_q == FILL) state_d = RUN;
    if (accept) begin
      state_d = RECONF;
      req_d = (bus.cfg_delay == '0) ? ONE : bus.cfg_delay;
    end
    if (state_q == RECONF) begin
      cur_d = req_q;
`ifdef DELAY_CTRL_FLUSH_EN
      state_d = FILL;
      fill_d = '0;
`else
      state_d = RUN;
      fill_d = req_q - ONE;
`endif
    end
    ready_d = state_d != RECONF;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= FILL;
      wr_ptr_q <= '0;
      fill_q <= '0;
      cur_q <= ADDR_W'(DEFAULT_DELAY);
      req_q <= '0;
      dout_q <= '0;
      dout_vld_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q <= fill_d;
      cur_q <= cur_d;
      req_q <= req_d;
      ready_q <= ready_d;
      dout_vld_q <= emit;
      if (bus.vld) wr_ptr_q <= wr_ptr_q + ONE;
      if (emit) dout_q <= (cur_q == ONE) ? bus.din : mem[rd_addr];
    end
  end
  always_ff @(posedge clk) begin
    if (bus.vld) mem[wr_ptr_q] <= bus.din;
  end
  assign bus.dout = dout_q;
  assign bus.dout_vld = dout_vld_q;
  assign bus.cfg_ready = ready_q;
  assign bus.cur_delay = cur_q;
  assign bus.state = state_q;
endmodule

// File: tb/tb_delay_ctrl.sv
// tb_delay_ctrl: randomized bench for delay_ctrl against a sample-history reference model.
module tb_delay_ctrl;
  localparam int DW = 16;
  localparam int AW = 10;
  localparam int DEF = 17;
`ifdef DELAY_CTRL_FLUSH_EN
  localparam bit FLUSH = 1'b1;
`else
  localparam bit FLUSH = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  delay_ctrl_if #(.D_WIDTH(DW), .ADDR_W(AW)) bus ();
  delay_ctrl #(.D_WIDTH(DW), .ADDR_W(AW), .DEFAULT_DELAY(DEF)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_vec = 0;
  int n_err = 0;
  // model: every sample since reset, delay in effect, vlds since last prime
  logic [DW-1:0] hist[$];
  int m_d = DEF;
  int m_cnt = 0;
  int m_req = 1;
  bit m_rc = 1'b0;
  bit m_acc = 1'b0;
  bit e_vld = 1'b0;
  bit e_ready = 1'b0;
  bit e_known = 1'b1;
  logic [DW-1:0] e_dout = '0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input bit rn, input bit v, input logic [DW-1:0] d, input bit cv, input int cd);
    int idx;
    reset_n = rn;
    bus.vld = v;
    bus.din = d;
    bus.cfg_valid = cv;
    bus.cfg_delay = AW'(cd);
    m_acc = 1'b0;
    if (!rn) begin
      hist.delete();
      m_d = DEF;
      m_cnt = 0;
      m_rc = 1'b0;
      e_vld = 1'b0;
      e_ready = 1'b0;
      e_dout = '0;
      e_known = 1'b1;
    end else begin
      e_vld = 1'b0;
      if (v) begin
        hist.push_back(d);
        if (m_cnt >= m_d - 1) begin
          e_vld = 1'b1;
          idx = hist.size() - m_d;
          e_known = idx >= 0;
          if (idx >= 0) e_dout = hist[idx];
        end
        m_cnt++;
      end
      if (m_rc) begin
        m_d = m_req;
        m_cnt = FLUSH ? 0 : m_d;
        m_rc = 1'b0;
      end else if (cv && e_ready) begin
        m_req = (cd == 0) ? 1 : cd;
        m_rc = 1'b1;
        m_acc = 1'b1;
      end
      e_ready = !m_rc;
    end
    @(posedge clk);
    #1;
    check("dout_vld", bus.dout_vld, e_vld);
    if (e_known) check("dout", bus.dout, e_dout);
    check("cfg_ready", bus.cfg_ready, e_ready);
    check("cur_delay", bus.cur_delay, m_d);
    check("state", bus.state, m_rc ? 2 : (m_cnt >= m_d ? 1 : 0));
  endtask
  task automatic request(input int cd, input bit all_vld);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, all_vld | 1'($urandom_range(1)), DW'($urandom), 1'b1, cd);
      if (m_acc) break;
    end
  endtask
  task automatic run(input int n, input int period);
    bit v;
    for (int i = 0; i < n; i++) begin
      v = (period == 0) ? 1'($urandom_range(1)) : (i % period == 0);
      cycle(1'b1, v, DW'($urandom), 1'b0, 0);
    end
  endtask
  task automatic random_phase(input int n);
    bit pend = 1'b0;
    bit cv;
    int pcd = 1;
    int cd;
    int sel;
    for (int i = 0; i < n; i++) begin
      if (!pend && $urandom_range(60) == 0) begin
        pend = 1'b1;
        sel = $urandom_range(9);
        pcd = (sel == 0) ? 0 : (sel == 1) ? 1 : (sel == 2) ? 200 : $urandom_range(40, 2);
      end
      cv = pend || (m_rc && $urandom_range(1) == 1);
      cd = pend ? pcd : $urandom_range(1023);
      cycle(1'b1, $urandom_range(3) != 0, DW'($urandom), cv, cd);
      if (m_acc) pend = 1'b0;
    end
  endtask
  initial begin
    bus.vld = 1'b0;
    bus.din = '0;
    bus.cfg_valid = 1'b0;
    bus.cfg_delay = '0;
    repeat (3) cycle(1'b0, 1'b1, DW'($urandom), 1'b1, 5);
    for (int i = 1; i <= 40; i++) cycle(1'b1, 1'b1, DW'(i), 1'b0, 0);
    request(5, 1'b0);
    run(60, 3);
    request(17, 1'b0);
    run(30, 1);
    request(4, 1'b1);
    run(30, 1);
    request(0, 1'b1);
    run(20, 0);
    request(1023, 1'b0);
    run(2200, 1);
    random_phase(3000);
    request(8, 1'b1);
    run(30, 1);
    cycle(1'b0, 1'b1, DW'($urandom), 1'b0, 0);
    run(40, 1);
    random_phase(500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
